// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcode and control-state encodings used by every MU0 variant
// and by the assembler-driven benches.
package mu0_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_JMP = 4'd4,
    OP_JGE = 4'd5,
    OP_JNE = 4'd6,
    OP_STP = 4'd7,
    OP_OUT = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Opcodes that fetch an operand from memory during EXEC.
  function automatic logic op_reads(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_datapath.sv
// MU0 accumulator and program counter: ALU add/sub, PC increment and branch decision.
// Updates only on the completion strobes from the control FSM, so stalls freeze it.
module mu0_datapath
  import mu0_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_done_i,
  input  logic                  exec_done_i,
  input  logic [3:0]            opcode_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  take_branch;

  always_comb begin
    take_branch = 1'b0;
    case (opcode_i)
      OP_JMP:  take_branch = 1'b1;
      OP_JGE:  take_branch = ~acc_q[DATA_WIDTH-1];
      OP_JNE:  take_branch = |acc_q;
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    pc_d  = pc_q;
    if (fetch_done_i) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
    if (exec_done_i) begin
      case (opcode_i)
        OP_LDA:  acc_d = rdata_i;
        OP_ADD:  acc_d = acc_q + rdata_i;
        OP_SUB:  acc_d = acc_q - rdata_i;
        default: acc_d = acc_q;
      endcase
      if (take_branch) begin
        pc_d = target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      pc_q  <= '0;
    end else begin
      acc_q <= acc_d;
      pc_q  <= pc_d;
    end
  end

  assign acc_o = acc_q;
  assign pc_o  = pc_q;

endmodule

// File: rtl/mu0_cpu_waitreq.sv
// MU0 CPU on one shared memory port with waitrequest stalls; FETCH/EXEC/HALTED control
// and bus requests live here, arithmetic and PC in mu0_datapath. Adds registered OUT strobe.
module mu0_cpu_waitreq
  import mu0_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  running,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] writedata,
  input  logic [DATA_WIDTH-1:0] readdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  fetch_done, exec_done;
  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand_addr;
  logic [DATA_WIDTH-1:0] acc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  unused_instr;

  assign opcode       = instr_q[DATA_WIDTH-1 -: 4];
  assign operand_addr = instr_q[ADDR_WIDTH-1:0];
  // Operand bits above the address width are architecturally ignored.
  assign unused_instr = ^instr_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    address     = pc;
    read        = 1'b0;
    write       = 1'b0;
    fetch_done  = 1'b0;
    exec_done   = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      ST_FETCH: begin
        read = 1'b1;
        if (!waitrequest) begin
          fetch_done = 1'b1;
          instr_d    = readdata;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        address = operand_addr;
        read    = op_reads(opcode);
        write   = (opcode == OP_STO);
        // Only a memory op can be stalled; everything else retires in one cycle.
        if (!((read || write) && waitrequest)) begin
          exec_done = 1'b1;
          state_d   = (opcode == OP_STP) ? ST_HALTED : ST_FETCH;
          if (opcode == OP_OUT) begin
            out_valid_d = 1'b1;
            out_data_d  = acc;
          end
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      instr_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  mu0_datapath #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .fetch_done_i(fetch_done),
    .exec_done_i (exec_done),
    .opcode_i    (opcode),
    .target_i    (operand_addr),
    .rdata_i     (readdata),
    .acc_o       (acc),
    .pc_o        (pc)
  );

  assign running   = (state_q != ST_HALTED);
  assign writedata = acc;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mu0_cpu_waitreq.sv
// Bench for mu0_cpu_waitreq: program table with write/OUT scoreboards on a stalling memory
// model, hand sequences for reset and mid-stall reset, and a second 8/24-bit build.
module tb_mu0_cpu_waitreq;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (12/16) ----------------
  logic          rst;
  logic          running, read, write, waitrequest, out_valid;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata, readdata, out_data;

  mu0_cpu_waitreq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .running(running), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .readdata(readdata),
    .out_valid(out_valid), .out_data(out_data)
  );

  logic [DW-1:0] mem [0:4095];
  int stall_n = 0;
  int wcnt = 0;

  assign waitrequest = (read || write) && (wcnt < stall_n);
  // Garbage on readdata while stalled so an early capture is visible.
  assign readdata = waitrequest ? ~mem[address] : mem[address];

  always @(posedge clk) begin
    if (rst) wcnt <= 0;
    else if (read || write) begin
      if (wcnt < stall_n) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        if (write) mem[address] <= writedata;
      end
    end
  end

  // ---------------- DUT 2 (8/24) ----------------
  logic          rst2;
  logic          running2, read2, write2, waitrequest2, out_valid2;
  logic [7:0]    address2;
  logic [23:0]   writedata2, readdata2, out_data2;

  mu0_cpu_waitreq #(.ADDR_WIDTH(8), .DATA_WIDTH(24)) dut2 (
    .clk(clk), .rst(rst2), .running(running2), .address(address2), .read(read2), .write(write2),
    .waitrequest(waitrequest2), .writedata(writedata2), .readdata(readdata2),
    .out_valid(out_valid2), .out_data(out_data2)
  );

  logic [23:0] mem2 [0:255];
  int wcnt2 = 0;
  assign waitrequest2 = (read2 || write2) && (wcnt2 < 1);
  assign readdata2 = waitrequest2 ? ~mem2[address2] : mem2[address2];

  always @(posedge clk) begin
    if (rst2) wcnt2 <= 0;
    else if (read2 || write2) begin
      if (wcnt2 < 1) wcnt2 <= wcnt2 + 1;
      else begin
        wcnt2 <= 0;
        if (write2) mem2[address2] <= writedata2;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  function void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  logic [27:0] exp_wr [$];
  logic [15:0] exp_out [$];
  logic        stall_prev = 1'b0;
  logic [AW-1:0] p_addr;
  logic [1:0]  p_rw;

  always @(negedge clk) begin
    if (!rst) begin
      if (write && !waitrequest) begin
        check("wr_excl", {31'd0, read}, 32'd0);
        if (exp_wr.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected: got %h:%h expected no write", address, writedata);
        end else check("wr", {4'd0, address, writedata}, {4'd0, exp_wr.pop_front()});
      end
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got pulse data %h expected none", out_data);
        end else check("out", {16'd0, out_data}, {16'd0, exp_out.pop_front()});
      end
      if (stall_prev) begin
        check("stall_addr", {20'd0, address}, {20'd0, p_addr});
        check("stall_rw", {30'd0, read, write}, {30'd0, p_rw});
      end
      stall_prev = (read || write) && waitrequest;
      p_addr = address;
      p_rw = {read, write};
    end else stall_prev = 1'b0;
  end

  int out2_cnt = 0;
  logic [23:0] out2_seen = '0;
  always @(negedge clk) begin
    if (!rst2 && out_valid2) begin
      out2_cnt++;
      out2_seen = out_data2;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] prog [0:15];
    logic [15:0] dat [0:1];    // at 0x100, 0x101
    int          stall;
    int          n_wr;
    logic [27:0] wr [0:1];     // {address, data}
    int          n_out;
    logic [15:0] outs [0:1];
    int          cycles;
  } vec_t;

  vec_t vecs [0:5];

  task automatic init_vecs();
    vecs[0].name = "basic";
    vecs[0].prog = '{0:16'h0100, 1:16'h2101, 2:16'h1102, default:16'h7000};
    vecs[0].dat  = '{16'd3, 16'd4};
    vecs[0].stall = 0; vecs[0].n_wr = 1; vecs[0].wr = '{28'h1020007, 28'h0};
    vecs[0].n_out = 0; vecs[0].outs = '{16'h0, 16'h0}; vecs[0].cycles = 8;

    // Seven accesses (four fetches, three data) each stalled three cycles.
    vecs[1] = vecs[0];
    vecs[1].name = "basic_stall3"; vecs[1].stall = 3; vecs[1].cycles = 8 + 7 * 3;

    vecs[2].name = "wrap";
    vecs[2].prog = '{0:16'h0100, 1:16'h2101, 2:16'h1102, 3:16'h3101, 4:16'h1103, default:16'h7000};
    vecs[2].dat  = '{16'hFFFF, 16'h0001};
    vecs[2].stall = 0; vecs[2].n_wr = 2; vecs[2].wr = '{28'h1020000, 28'h103FFFF};
    vecs[2].n_out = 0; vecs[2].outs = '{16'h0, 16'h0}; vecs[2].cycles = 12;

    // JNE(0) no, LDA -1, JGE no, LDA 1, JGE yes ->7, OUT, JMP FFF, NOP, wrap to 0: JNE yes ->5 STP
    vecs[3].name = "branch";
    vecs[3].prog = '{0:16'h6005, 1:16'h0100, 2:16'h5006, 3:16'h0101, 4:16'h5007,
                     5:16'h7000, 6:16'h7000, 7:16'h8000, 8:16'h4FFF, default:16'h7000};
    vecs[3].dat  = '{16'hFFFF, 16'h0001};
    vecs[3].stall = 0; vecs[3].n_wr = 0; vecs[3].wr = '{28'h0, 28'h0};
    vecs[3].n_out = 1; vecs[3].outs = '{16'h0001, 16'h0}; vecs[3].cycles = 20;

    vecs[4].name = "out";
    vecs[4].prog = '{0:16'h0005, 1:16'h8000, 2:16'h8000, 5:16'd42, default:16'h7000};
    vecs[4].dat  = '{16'h0, 16'h0};
    vecs[4].stall = 0; vecs[4].n_wr = 0; vecs[4].wr = '{28'h0, 28'h0};
    vecs[4].n_out = 2; vecs[4].outs = '{16'd42, 16'd42}; vecs[4].cycles = 8;

    vecs[5] = vecs[4];
    vecs[5].name = "out_stall2"; vecs[5].stall = 2; vecs[5].cycles = 8 + 5 * 2;
  endtask

  task automatic run_to_halt(input string nm, input int exp_cycles);
    int cyc;
    cyc = 0;
    while (running && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_halted"}, {31'd0, running}, 32'd0);
    if (exp_cycles >= 0) check({nm, "_cycles"}, cyc, exp_cycles);
  endtask

  task automatic run_vec(input int k);
    @(posedge clk); #1 rst = 1'b1;
    for (int a = 0; a < 4096; a++) mem[a] <= 16'h7000;
    mem[12'hFFF] <= 16'h9000;
    for (int a = 0; a < 16; a++) mem[a] <= vecs[k].prog[a];
    mem[12'h100] <= vecs[k].dat[0];
    mem[12'h101] <= vecs[k].dat[1];
    stall_n = vecs[k].stall;
    exp_wr.delete();
    exp_out.delete();
    for (int i = 0; i < vecs[k].n_wr; i++) exp_wr.push_back(vecs[k].wr[i]);
    for (int i = 0; i < vecs[k].n_out; i++) exp_out.push_back(vecs[k].outs[i]);
    @(posedge clk); #1 rst = 1'b0;
    run_to_halt(vecs[k].name, vecs[k].cycles);
    check({vecs[k].name, "_wr_left"}, exp_wr.size(), 32'd0);
    check({vecs[k].name, "_out_left"}, exp_out.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    logic found;
    rst = 1'b1;
    rst2 = 1'b1;
    init_vecs();
    repeat (2) @(posedge clk);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Halted after the OUT program: bus idle, out_data held.
    repeat (3) @(posedge clk);
    #1;
    check("halt_running", {31'd0, running}, 32'd0);
    check("halt_rw", {30'd0, read, write}, 32'd0);
    check("halt_out_valid", {31'd0, out_valid}, 32'd0);
    check("halt_out_data", {16'd0, out_data}, 32'd42);

    // Reset from HALTED.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_running", {31'd0, running}, 32'd1);
    check("rst_read", {31'd0, read}, 32'd1);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_address", {20'd0, address}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_acc", {16'd0, writedata}, 32'd0);

    // Reset in the middle of a stalled STO: the store must be abandoned.
    for (int a = 0; a < 4096; a++) mem[a] <= 16'h7000;
    mem[0] <= 16'h0101;
    mem[1] <= 16'h1100;
    mem[12'h100] <= 16'h1234;
    mem[12'h101] <= 16'h5555;
    stall_n = 3;
    exp_wr.delete();
    exp_out.delete();
    exp_wr.push_back({12'h100, 16'h5555});
    @(posedge clk); #1 rst = 1'b0;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (write && waitrequest) found = 1'b1;
    end
    check("ms_sto_stall_seen", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ms_write", {31'd0, write}, 32'd0);
    check("ms_read", {31'd0, read}, 32'd1);
    check("ms_address", {20'd0, address}, 32'd0);
    check("ms_mem_kept", {16'd0, mem[12'h100]}, 32'h1234);
    rst = 1'b0;
    run_to_halt("ms_rerun", -1);
    check("ms_mem_final", {16'd0, mem[12'h100]}, 32'h5555);
    check("ms_wr_left", exp_wr.size(), 32'd0);

    // 8-bit address / 24-bit data build: wrap arithmetic, truncated operands, PC wrap.
    for (int a = 0; a < 256; a++) mem2[a] <= 24'h700000;
    mem2[8'h00] <= 24'h600010;   // JNE 0x10
    mem2[8'h01] <= 24'h012380;   // LDA 0x80 (high operand bits ignored)
    mem2[8'h02] <= 24'h200081;   // ADD 0x81
    mem2[8'h03] <= 24'h100082;   // STO 0x82
    mem2[8'h04] <= 24'h300081;   // SUB 0x81
    mem2[8'h05] <= 24'h800000;   // OUT
    mem2[8'h06] <= 24'h4ABCFF;   // JMP 0xFF
    mem2[8'hFF] <= 24'h900000;   // NOP, then fetch wraps to 0
    mem2[8'h80] <= 24'hFFFFFF;
    mem2[8'h81] <= 24'h000001;
    mem2[8'h82] <= 24'h123456;
    @(posedge clk); #1 rst2 = 1'b0;
    cyc = 0;
    while (running2 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w24_halted", {31'd0, running2}, 32'd0);
    // Ten instructions, fourteen accesses each stalled once.
    check("w24_cycles", cyc, 32'd34);
    check("w24_store", {8'd0, mem2[8'h82]}, 32'h0);
    check("w24_out_pulses", out2_cnt, 32'd1);
    check("w24_out_seen", {8'd0, out2_seen}, 32'hFFFFFF);
    check("w24_out_held", {8'd0, out_data2}, 32'hFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
